// File: rtl/aes_key_schedule_ctrl.sv
// Sequencer for a single-round AES-128 key-expansion datapath. It steps rounds 1..NROUNDS,
// keeps every round key in a local store and serves them through a registered read port.
module aes_key_schedule_ctrl #(
  parameter int NROUNDS = 10,
  parameter int EXP_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic [127:0] exp_key,
  output logic [3:0]   exp_round,
  input  logic [127:0] exp_next,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic [3:0]   rk_rd_addr,
  output logic [127:0] rk_rd_data
);

  localparam logic [3:0] LAST_RND = 4'(NROUNDS);
  localparam logic [3:0] LAT      = 4'(EXP_LAT);

  generate
    if (NROUNDS < 1 || NROUNDS > 14 || EXP_LAT < 0 || EXP_LAT > 15) begin : g_param_chk
      $error("aes_key_schedule_ctrl: NROUNDS must be 1..14 and EXP_LAT 0..15");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t         state_q;
  logic [3:0]     round_q;
  logic [3:0]     cnt_q;
  logic [127:0]   key_q;
  logic           busy_q;
  logic           done_q;
  logic           kv_q;
  logic [127:0]   rd_q;
  logic [127:0]   rd_d;
  logic [127:0]   store_q [0:NROUNDS];
  logic           start_acc;
  logic           cap;

  assign start_acc = (state_q == IDLE) && start;
  assign cap       = (state_q == RUN) && (cnt_q == LAT);

  // key_q doubles as the running "previous round key"; round_q reads 0 outside RUN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      round_q <= 4'd0;
      cnt_q   <= 4'd0;
      key_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      kv_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            key_q   <= key_in;
            round_q <= 4'd1;
            cnt_q   <= 4'd0;
            kv_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (cnt_q == LAT) begin
            key_q <= exp_next;
            cnt_q <= 4'd0;
            if (round_q == LAST_RND) begin
              round_q <= 4'd0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              kv_q    <= 1'b1;
              state_q <= FIN;
            end else begin
              round_q <= round_q + 4'd1;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Store holds data only and is never cleared by reset
  always_ff @(posedge clk) begin
    if (rst_n && start_acc) store_q[0] <= key_in;
    if (rst_n && cap)       store_q[round_q] <= exp_next;
  end

  always_comb begin
    rd_d = '0;
    if (rk_rd_addr <= LAST_RND) rd_d = store_q[rk_rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rd_q <= '0;
    else        rd_q <= rd_d;
  end

  assign exp_key    = key_q;
  assign exp_round  = round_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign keys_valid = kv_q;
  assign rk_rd_data = rd_q;

endmodule
